// File: rtl/compunit_ne_pkg.sv
// Shared sizing and compressed-row layout for the min-sum check-node datapath.
// The downstream recovery stage imports this same package to unpack Ecomp.
package compunit_ne_pkg;

    localparam int W         = 6;
    localparam int Wabs      = W - 1;
    localparam int Wc        = 18;
    localparam int Wcbits    = 5;
    localparam int ECOMPSIZE = 2 * Wabs + Wcbits + Wc;

    localparam int USIGN_LSB = 0;
    localparam int POS_LSB   = USIGN_LSB + Wc;
    localparam int MIN2_LSB  = POS_LSB + Wcbits;
    localparam int MIN1_LSB  = MIN2_LSB + Wabs;

    // Field order matches the bit offsets above, MSB first.
    typedef struct packed {
        logic [Wabs-1:0]   min1;
        logic [Wabs-1:0]   min2;
        logic [Wcbits-1:0] pos;
        logic [Wc-1:0]     usign;
    } ecomp_t;

endpackage

// File: rtl/compunit_ne_abs_sat.sv
// Splits a two's-complement message into sign and magnitude; the most-negative
// code has no positive counterpart and is clamped to the largest magnitude.
module compunit_ne_abs_sat
    import compunit_ne_pkg::*;
(
    input  logic [W-1:0]    data_i,
    output logic            sign_o,
    output logic [Wabs-1:0] mag_o
);

    function automatic logic [Wabs-1:0] sat_abs(input logic signed [W-1:0] x);
        logic signed [W-1:0] neg;
        neg = -x;
        if (x == {1'b1, {Wabs{1'b0}}})
            return {Wabs{1'b1}};
        return x[W-1] ? neg[Wabs-1:0] : x[Wabs-1:0];
    endfunction

    assign sign_o = data_i[W-1];
    assign mag_o  = sat_abs(data_i);

endmodule

// File: rtl/compunit_ne.sv
// Row compression stage: folds Wc serial messages into {Min1, Min2, Pos, sign}
// with a one-deep output register that lets the next row accumulate behind it.
module compunit_ne
    import compunit_ne_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ECOMPSIZE-1:0] Ecomp
);

    localparam logic [Wcbits-1:0] LAST = Wcbits'(Wc - 1);

    logic [Wcbits-1:0] cnt_q, cnt_d;
    logic [Wabs-1:0]   m1_q, m1_d, m2_q, m2_d;
    logic [Wcbits-1:0] p_q, p_d;
    logic [Wc-1:0]     sgn_q, sgn_d;
    logic              tot_q, tot_d;
    logic              out_valid_q;
    ecomp_t            ecomp_q, ecomp_d;

    logic              s;
    logic [Wabs-1:0]   mag;
    logic              beat, last_beat;
    logic              first;
    logic [Wabs-1:0]   m1_run, m2_run;
    logic [Wcbits-1:0] p_run;
    logic              tot_run;

    compunit_ne_abs_sat u_abs_sat (
        .data_i (in_data),
        .sign_o (s),
        .mag_o  (mag)
    );

    // Only the closing beat of a row needs the output register to be free.
    assign in_ready  = !(out_valid_q && !out_ready && (cnt_q == LAST));
    assign beat      = in_valid && in_ready;
    assign last_beat = beat && (cnt_q == LAST);
    assign out_valid = out_valid_q;
    assign Ecomp     = ecomp_q;

    always_comb begin
        // At index 0 the stale accumulators are replaced by neutral values, so no clear cycle is needed.
        first   = (cnt_q == '0);
        m1_run  = first ? {Wabs{1'b1}} : m1_q;
        m2_run  = first ? {Wabs{1'b1}} : m2_q;
        p_run   = first ? '0 : p_q;
        tot_run = first ? 1'b0 : tot_q;

        m1_d = m1_run;
        m2_d = m2_run;
        p_d  = p_run;
        if (mag < m1_run) begin
            m2_d = m1_run;
            m1_d = mag;
            p_d  = cnt_q;
        end else if (mag < m2_run) begin
            m2_d = mag;
        end

        sgn_d        = sgn_q;
        sgn_d[cnt_q] = s;
        tot_d        = tot_run ^ s;
        cnt_d        = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;

        ecomp_d.min1  = m1_d;
        ecomp_d.min2  = m2_d;
        ecomp_d.pos   = p_d;
        ecomp_d.usign = sgn_d ^ {Wc{tot_d}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            ecomp_q     <= '0;
        end else begin
            if (beat)
                cnt_q <= cnt_d;
            if (last_beat) begin
                ecomp_q     <= ecomp_d;
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (beat) begin
            m1_q  <= m1_d;
            m2_q  <= m2_d;
            p_q   <= p_d;
            sgn_q <= sgn_d;
            tot_q <= tot_d;
        end
    end

endmodule

// File: tb/tb_compunit_ne.sv
// Scoreboarded bench for compunit_ne: a min-sum row model feeds an expected
// queue, and an independent monitor compares every transferred Ecomp.
module tb_compunit_ne;
    import compunit_ne_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [W-1:0]         in_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [ECOMPSIZE-1:0] Ecomp;

    int errors = 0;
    int checks = 0;
    int vld_cycles = 0;
    bit rand_rdy = 1'b0;

    int                   row[$];
    logic [ECOMPSIZE-1:0] exp_q[$];

    compunit_ne dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Ecomp     (Ecomp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Reference: min over magnitudes, second min excluding one copy of the winner, extrinsic parity.
    task automatic model_accept(input logic signed [W-1:0] v);
        int     mags[Wc];
        int     negs;
        int     pos;
        int     mn1;
        int     mn2;
        ecomp_t er;
        row.push_back(int'(v));
        if (row.size() == Wc) begin
            negs = 0; pos = 0; mn1 = 1 << W; mn2 = 1 << W;
            for (int i = 0; i < Wc; i++) begin
                mags[i] = (row[i] < 0) ? -row[i] : row[i];
                if (mags[i] > (1 << Wabs) - 1) mags[i] = (1 << Wabs) - 1;
                if (row[i] < 0) negs++;
            end
            for (int i = 0; i < Wc; i++)
                if (mags[i] < mn1) begin mn1 = mags[i]; pos = i; end
            for (int i = 0; i < Wc; i++)
                if (i != pos && mags[i] < mn2) mn2 = mags[i];
            er.min1 = Wabs'(mn1);
            er.min2 = Wabs'(mn2);
            er.pos  = Wcbits'(pos);
            for (int i = 0; i < Wc; i++)
                er.usign[i] = ((negs - ((row[i] < 0) ? 1 : 0)) % 2) == 1;
            exp_q.push_back(er);
            row.delete();
        end
    endtask

    task automatic send(input logic signed [W-1:0] v, input bit gaps);
        bit acc;
        int n;
        if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = v;
        acc = 1'b0;
        n = 0;
        while (!acc) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                model_accept(v);
            end
            n++;
            @(posedge clk); #1;
            if (!acc && n > 200) begin
                check("accept_timeout", 64'(n), 64'(0));
                acc = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_pattern(input int kind);
        for (int k = 0; k < Wc; k++) begin
            case (kind)
                0: send((k == 0) ? -6'sd3 : (k == 5) ? 6'sd2 : 6'sd10, 1'b0);
                1: send(6'sd7, 1'b0);
                default: send(-6'sd32, 1'b0);
            endcase
        end
    endtask

    // Monitor: pops on every transfer and checks that a stalled word stays put.
    initial begin
        logic [ECOMPSIZE-1:0] held;
        bit                   held_ok;
        held_ok = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (out_valid) vld_cycles++;
            if (rst) begin
                held_ok = 1'b0;
            end else if (out_valid && out_ready) begin
                if (exp_q.size() == 0)
                    check("unexpected_output", 64'(Ecomp), 64'(0));
                else
                    check("ecomp_scoreboard", 64'(Ecomp), 64'(exp_q.pop_front()));
                held_ok = 1'b0;
            end else if (out_valid) begin
                if (held_ok) check("ecomp_held", 64'(Ecomp), 64'(held));
                held    = Ecomp;
                held_ok = 1'b1;
            end else begin
                held_ok = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int snap;
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_ecomp", 64'(Ecomp), 64'(0));
        check("reset_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;

        send_pattern(0);
        @(negedge clk);
        check("single_valid", 64'(out_valid), 64'(1));
        check("single_ecomp", 64'(Ecomp), 64'({5'd2, 5'd3, 5'd5, 18'h3FFFE}));
        @(posedge clk); #1;

        send_pattern(1);
        @(negedge clk);
        check("ties_ecomp", 64'(Ecomp), 64'({5'd7, 5'd7, 5'd0, 18'h00000}));
        @(posedge clk); #1;

        send_pattern(2);
        @(negedge clk);
        check("sat_ecomp", 64'(Ecomp), 64'({5'd31, 5'd31, 5'd0, 18'h3FFFF}));
        @(posedge clk); #1;

        for (int k = 0; k < 7; k++) send(6'sd1, 1'b0);
        rst = 1'b1;
        row.delete();
        @(negedge clk);
        check("midreset_valid_during", 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midreset_valid_after", 64'(out_valid), 64'(0));
        check("midreset_in_ready", 64'(in_ready), 64'(1));
        check("midreset_ecomp", 64'(Ecomp), 64'(0));
        @(posedge clk); #1;
        send_pattern(0);
        @(negedge clk);
        check("midreset_row_ecomp", 64'(Ecomp), 64'({5'd2, 5'd3, 5'd5, 18'h3FFFE}));
        @(posedge clk); #1;

        out_ready = 1'b0;
        for (int k = 0; k < 2 * Wc - 1; k++) send(6'(signed'($urandom_range(0, 63))), 1'b0);
        in_valid = 1'b1;
        in_data  = 6'(signed'($urandom_range(0, 63)));
        repeat (3) begin
            @(negedge clk);
            check("bp_stall_in_ready", 64'(in_ready), 64'(0));
            check("bp_stall_valid", 64'(out_valid), 64'(1));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 64'(in_ready), 64'(1));
        model_accept(in_data);
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        check("bp_row2_valid", 64'(out_valid), 64'(1));
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;

        snap = vld_cycles;
        for (int k = 0; k < 3 * Wc; k++) send(6'(signed'($urandom_range(0, 63))), 1'b0);
        repeat (2) @(negedge clk);
        check("b2b_valid_cycles", 64'(vld_cycles - snap), 64'(3));
        @(posedge clk); #1;

        rand_rdy = 1'b1;
        for (int k = 0; k < 5 * Wc; k++) send(6'(signed'($urandom_range(0, 63))), 1'b1);
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
        check("drain_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
